// File: rtl/mem_rr_arb.sv
// rtl/mem_rr_arb.sv - round-robin arbiter and sequencer for the shared memory bus
// Optional MEM_ARB_LOCK_EN adds a locks port that re-grants the same client for read-modify-write.
module mem_rr_arb #(
  parameter int M_WIDTH     = 8,
  parameter int CLIENT_CNT  = 3,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CLIENT_CNT-1:0]         requests,
  input  logic [CLIENT_CNT*M_WIDTH-1:0] addrs,
  input  logic [CLIENT_CNT-1:0]         wes,
  input  logic [CLIENT_CNT*M_WIDTH-1:0] data_outs,
  input  logic [M_WIDTH-1:0]            mem_data_in,
`ifdef MEM_ARB_LOCK_EN
  input  logic [CLIENT_CNT-1:0]         locks,
`endif
  output logic [CLIENT_CNT-1:0]         readies,
  output logic [M_WIDTH-1:0]            data_in,
  output logic [M_WIDTH-1:0]            addr,
  output logic [M_WIDTH-1:0]            data_out,
  output logic                          we,
  output logic [$clog2(CLIENT_CNT)-1:0] grant_id,
  output logic                          busy
);

  localparam int IDW = $clog2(CLIENT_CNT);
  localparam int CW  = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      last_grant_q, last_grant_d;
  logic [IDW-1:0]      grant_id_q, grant_id_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [M_WIDTH-1:0]  addr_q, addr_d;
  logic [M_WIDTH-1:0]  data_out_q, data_out_d;
  logic [M_WIDTH-1:0]  data_in_q, data_in_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic [CLIENT_CNT-1:0] readies_q, readies_d;

  logic                rr_found;
  logic [IDW-1:0]      rr_idx;
  logic [IDW-1:0]      rr_cand;
  logic                pick_valid;
  logic [IDW-1:0]      pick_idx;

`ifdef MEM_ARB_LOCK_EN
  logic                lock_q, lock_d;
  logic                relock;

  assign relock = lock_q && requests[grant_id_q] && locks[grant_id_q];
`endif

  // Scan starts one past the last grant so the most recent winner has lowest priority.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int k = 1; k <= CLIENT_CNT; k++) begin
      rr_cand = IDW'((int'(last_grant_q) + k) % CLIENT_CNT);
      if (!rr_found && requests[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  always_comb begin
    pick_valid = rr_found;
    pick_idx   = rr_idx;
`ifdef MEM_ARB_LOCK_EN
    if (relock) begin
      pick_valid = 1'b1;
      pick_idx   = grant_id_q;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    data_out_d   = data_out_q;
    data_in_d    = data_in_q;
    we_d         = we_q;
    busy_d       = busy_q;
    readies_d    = readies_q;
`ifdef MEM_ARB_LOCK_EN
    lock_d       = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
        we_d = 1'b0;
`ifdef MEM_ARB_LOCK_EN
        lock_d = relock;
`endif
        if (pick_valid) begin
          addr_d     = addrs[int'(pick_idx)*M_WIDTH +: M_WIDTH];
          data_out_d = data_outs[int'(pick_idx)*M_WIDTH +: M_WIDTH];
          we_d       = wes[pick_idx];
          grant_id_d = pick_idx;
          cnt_d      = CW'(WAIT_CYCLES);
          busy_d     = 1'b1;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        we_d = 1'b0;
        if (cnt_q == CW'(1)) begin
          data_in_d             = mem_data_in;
          readies_d             = '0;
          readies_d[grant_id_q] = 1'b1;
          state_d               = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        if (!requests[grant_id_q]) begin
          readies_d    = '0;
          last_grant_d = grant_id_q;
          busy_d       = 1'b0;
          state_d      = ST_IDLE;
`ifdef MEM_ARB_LOCK_EN
          lock_d       = locks[grant_id_q];
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(CLIENT_CNT - 1);
      grant_id_q   <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_out_q   <= '0;
      data_in_q    <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      readies_q    <= '0;
`ifdef MEM_ARB_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_out_q   <= data_out_d;
      data_in_q    <= data_in_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      readies_q    <= readies_d;
`ifdef MEM_ARB_LOCK_EN
      lock_q       <= lock_d;
`endif
    end
  end

  assign readies  = readies_q;
  assign data_in  = data_in_q;
  assign addr     = addr_q;
  assign data_out = data_out_q;
  assign we       = we_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: doc/mem_rr_arb.md
Name: mem_rr_arb

Overview:
- Round-robin arbiter and sequencer for the single shared 8-bit memory bus. Shares it between CLIENT_CNT requesters, e.g. fetch, exec and I/O DMA.
- Each client performs a 4-phase request/ready handshake.
- The block drives addr/data_out/we to memory, waits a fixed number of access cycles, then captures read data and returns it to the granted client.
- Replaces fixed-priority sharing with a fair, starvation-free scheme.

Parameters:
- M_WIDTH, 8, bus width for address and data.
- CLIENT_CNT, 3, number of requesters; must be >= 2.
- WAIT_CYCLES, 2, memory access latency in clk cycles from address issue to data valid; must be >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- requests  in  CLIENT_CNT  per-client request; held high until ready seen
- addrs  in  CLIENT_CNT*M_WIDTH  client i address in bits [i*M_WIDTH +: M_WIDTH]
- wes  in  CLIENT_CNT  per-client write enable
- data_outs  in  CLIENT_CNT*M_WIDTH  per-client write data, same packing as addrs
- mem_data_in  in  M_WIDTH  read data from memory
- readies  out  CLIENT_CNT  per-client completion, one-hot or zero
- data_in  out  M_WIDTH  captured read data, broadcast to all clients
- addr  out  M_WIDTH  memory address
- data_out  out  M_WIDTH  memory write data
- we  out  1  memory write strobe
- grant_id  out  $clog2(CLIENT_CNT)  index of current or last granted client
- busy  out  1  high while a transaction is in ACCESS or DONE

Behaviour:
- Reset (synchronous, overrides everything including mid-transaction):
  - Outputs: readies=0, we=0, addr=0, data_out=0, data_in=0, grant_id=0, busy=0.
  - Internal: state=IDLE, last_grant=CLIENT_CNT-1, so client 0 wins first, wait counter=0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If any request is high, pick the first requesting index scanning last_grant+1, last_grant+2, ... modulo CLIENT_CNT.
  - At edge E0: latch addr, data_out and we from that client; grant_id=index; counter=WAIT_CYCLES; busy=1; go to ACCESS.
  - If no request: we=0, stay in IDLE; addr/data_out hold their values.
- ACCESS:
  - we is forced to 0 at the first ACCESS edge, so it is high for exactly one cycle (after E0).
  - Each edge: if counter==1, then data_in<=mem_data_in, readies[grant_id]<=1, go to DONE; else counter<=counter-1.
  - Read data is sampled at edge E0+WAIT_CYCLES. readies becomes visible after that edge.
  - Writes also capture data_in; its value is don't-care for writes.
  - addr/data_out stay stable through ACCESS and DONE.
- DONE:
  - Wait until requests[grant_id]==0, then: readies<=0, last_grant<=grant_id, busy<=0, go to IDLE.
  - At least one IDLE cycle always separates consecutive grants.
- Other requesters keep their request high while waiting; no ready pulses are sent to them.
- Protocol violation, request dropped during ACCESS: the transaction still completes. ready pulses for exactly one cycle, then DONE exits on the next edge.
- Requests arriving in ACCESS/DONE are ignored until IDLE. Round-robin guarantees each waiting client is served within CLIENT_CNT grants.
- All index/counter arithmetic wraps modulo CLIENT_CNT; the pointer uses no width beyond $clog2(CLIENT_CNT).

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Defined:
  - Adds input port locks (CLIENT_CNT).
  - If locks[grant_id] is high when DONE exits, a lock flag is set.
  - In IDLE with the lock flag set and requests[grant_id] high, the same client is re-granted, bypassing round-robin. last_grant is not advanced.
  - Lock is released (flag cleared) when the locked client is not requesting in IDLE or drops its lock bit. Normal round-robin then resumes.
  - Used for read-modify-write sequences.
- Undefined: no locks port; pure round-robin.

Test Plan:
- Single read: client 1 requests, addr 0x42, we=0, mem_data_in=0xA5 -> after E0 addr=0x42, grant_id=1, busy=1. After E0+2, readies=3'b010, data_in=0xA5. Drop request -> readies=0 and busy=0 one edge later.
- Single write: client 0, addr 0x10, data 0x3C, we=1 -> addr=0x10, data_out=0x3C. we high for exactly one cycle. readies[0] high after E0+2.
- All three clients request continuously, each dropping its request one cycle after its ready and re-raising it -> grant_id order 0,1,2,0,1. No client is granted twice in a row.
- After a grant to client 1, clients 0 and 2 request simultaneously -> client 2 granted next, then client 0.
- rst asserted during ACCESS with we=1 -> next edge we=0, readies=0, busy=0. Client 2 and client 0 then requesting -> client 0 granted first.
- With MEM_ARB_LOCK_EN defined: client 1 holds locks[1]=1 across two transactions while client 2 also requests -> client 1 granted twice, then client 2. Without the macro -> order 1,2.
